// File: rtl/uart_pkg.sv
// Purpose: shared types and helpers for the parametrised UART blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: parity-mode constants, receiver state enum, counter width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Bits needed for a counter running 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: free-running clock-enable generator, one tick every div_q+1 clk.
// Latency: tick decodes the counter directly; a new divisor takes effect 1 clk after load.
// Backpressure: none; runs continuously.
// Ports: clk, reset (sync, active high), div (clk per tick minus 1),
//        load (capture div into div_q), tick (1-cycle enable pulse).
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // >= rather than == so that a divisor lowered while the counter sits above
  // it wraps immediately instead of running through the whole counter range.
  assign tick = (cnt >= div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      cnt   <= '0;
    end else begin
      if (load) div_q <= div;
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Purpose: parametrised single-clock UART receiver with valid/ready output and error flags.
// Latency: start edge to data_valid ~ (DATA_BITS + parity + STOP_BITS + 0.5) bit times + 2..div_q+4 clk.
// Backpressure: one word held until data_ready; a frame completing while held is dropped with overrun_err.
// Ports: clk, reset (sync, active high), baud_div, rx_in (async, idles high), data_ready,
//        data_out, data_valid, parity_err, frame_err, overrun_err (pulse), busy.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SAMP_W = cnt_w(OVERSAMPLE);
  localparam int BIT_W  = cnt_w(DATA_BITS);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_ADJ   = (PARITY == PAR_ODD);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 armed;
  logic                 done;

  // The divisor is only captured between frames so a mid-frame change
  // cannot stretch or shrink bits already being sampled.
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .div   (baud_div),
    .load  (state == ST_IDLE),
    .tick  (tick)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= ST_IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      armed    <= 1'b0;
      done     <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      done    <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            // A held-low line (break) must go high before a start is accepted.
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= ST_START;
              samp_cnt <= '0;
              bit_cnt  <= '0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
            end
          end
          ST_START: begin
            if (samp_cnt == SAMP_MID) begin
              samp_cnt <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;  // high at mid-bit: glitch
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (samp_cnt == SAMP_LAST) begin
              samp_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};  // LSB arrives first
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (samp_cnt == SAMP_LAST) begin
              samp_cnt <= '0;
              perr     <= rx_s ^ (^shreg) ^ ODD_ADJ;
              state    <= ST_STOP;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (samp_cnt == SAMP_LAST) begin
              samp_cnt <= '0;
              ferr     <= ferr | ~rx_s;
              if (bit_cnt == STOP_LAST) begin
                // Leave at mid-stop-bit so an immediately following start is caught.
                state <= ST_IDLE;
                done  <= 1'b1;
                if (ferr | ~rx_s) armed <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output holding register; completion wins over acceptance in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (done) begin
        if (data_valid && !data_ready) begin
          overrun_err <= 1'b1;
        end else begin
          data_out   <= shreg;
          parity_err <= perr;
          frame_err  <= ferr;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  localparam int BIT_CLK = 64;  // baud_div = 3, OVERSAMPLE = 16
  localparam int WAIT_BUDGET = 800;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        rx_a, rdy_a, rx_b, rdy_b;
  logic [7:0]  dout_a, dout_b;
  logic        vld_a, perr_a, ferr_a, ovr_a, busy_a;
  logic        vld_b, perr_b, ferr_b, ovr_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_param u_dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .rx_in(rx_a), .data_ready(rdy_a),
    .data_out(dout_a), .data_valid(vld_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(.PARITY(1)) u_dut_par (
    .clk(clk), .reset(reset), .baud_div(baud_div), .rx_in(rx_b), .data_ready(rdy_b),
    .data_out(dout_b), .data_valid(vld_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun_err(ovr_b), .busy(busy_b)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   frame_start_cyc = 0;
  int   rise_cyc_a = -1;
  int   rise_cnt_a = 0;
  int   vld_cnt_a = 0;
  int   ovr_cnt_a = 0;
  logic vld_a_d = 1'b0;
  rec_t exp_a[$], got_a[$], exp_b[$], got_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: captures every accepted word and tracks valid/overrun activity.
  always @(negedge clk) begin
    rec_t r;
    if (vld_a === 1'b1 && rdy_a === 1'b1) begin
      r.data = dout_a; r.perr = perr_a; r.ferr = ferr_a;
      got_a.push_back(r);
    end
    if (vld_b === 1'b1 && rdy_b === 1'b1) begin
      r.data = dout_b; r.perr = perr_b; r.ferr = ferr_b;
      got_b.push_back(r);
    end
    if (vld_a === 1'b1 && vld_a_d !== 1'b1) begin
      rise_cyc_a = cyc;
      rise_cnt_a++;
    end
    if (vld_a === 1'b1) vld_cnt_a++;
    if (ovr_a === 1'b1) ovr_cnt_a++;
    vld_a_d = vld_a;
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    @(posedge clk); #1;
    frame_start_cyc = cyc;
    set_line(sel, 1'b0);
    repeat (BIT_CLK) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    if (par_en) begin
      set_line(sel, par_bit);
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    set_line(sel, stop_bit);
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic wait_got(input bit sel, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < WAIT_BUDGET) begin
      if ((sel ? got_b.size() : got_a.size()) != 0) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    baud_div = 16'd3;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({vld_a, perr_a, ferr_a, ovr_a, busy_a, dout_a} !== 13'b0) begin
      bad++;
      $display("FAIL reset_a got=%b want=0", {vld_a, perr_a, ferr_a, ovr_a, busy_a, dout_a});
    end
    total++;
    if ({vld_b, perr_b, ferr_b, ovr_b, busy_b, dout_b} !== 13'b0) begin
      bad++;
      $display("FAIL reset_b got=%b want=0", {vld_b, perr_b, ferr_b, ovr_b, busy_b, dout_b});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (200) @(posedge clk);
  endtask

  task automatic test_basic();
    rec_t e, g;
    bit   ok;
    int   v0, lat;
    v0 = vld_cnt_a;
    e.data = 8'hA5; e.perr = 1'b0; e.ferr = 1'b0;
    exp_a.push_back(e);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_got(1'b0, ok);
    e = exp_a.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL basic_word timeout want=%h", e.data);
    end else begin
      g = got_a.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL basic_word got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
      end
    end
    lat = rise_cyc_a - frame_start_cyc;
    total++;
    if (lat < 610 || lat > 616) begin
      bad++; $display("FAIL basic_latency got=%0d want=610..616", lat);
    end
    repeat (4) @(negedge clk);
    total++;
    if (vld_cnt_a - v0 != 1) begin
      bad++; $display("FAIL basic_valid_width got=%0d want=1", vld_cnt_a - v0);
    end
  endtask

  task automatic test_parity();
    rec_t e, g;
    bit   ok;
    logic [7:0] pd [3];
    logic       pb [3];
    logic       pe [3];
    pd[0] = 8'h3C; pb[0] = 1'b1; pe[0] = 1'b1;
    pd[1] = 8'h3C; pb[1] = 1'b0; pe[1] = 1'b0;
    pd[2] = 8'h3D; pb[2] = 1'b1; pe[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.data = pd[i]; e.perr = pe[i]; e.ferr = 1'b0;
      exp_b.push_back(e);
      send_frame(1'b1, pd[i], 1'b1, pb[i], 1'b1);
      wait_got(1'b1, ok);
      e = exp_b.pop_front();
      total++;
      if (!ok) begin
        bad++; $display("FAIL parity_%0d timeout want=%h", i, e.data);
      end else begin
        g = got_b.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL parity_%0d got=%h/%b/%b want=%h/%b/%b", i, g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    rec_t e, g;
    bit   ok;
    int   bz;
    e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1;
    exp_a.push_back(e);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bz = 0;
    for (int i = 0; i < 3 * BIT_CLK; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b0) bz++;
    end
    total++;
    if (bz != 0) begin
      bad++; $display("FAIL break_busy busy_cycles=%0d want=0", bz);
    end
    wait_got(1'b0, ok);
    e = exp_a.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL ferr_word timeout want=%h", e.data);
    end else begin
      g = got_a.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL ferr_word got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
      end
    end
    total++;
    if (ferr_a !== 1'b1) begin
      bad++; $display("FAIL ferr_hold got=%b want=1", ferr_a);
    end
    @(posedge clk); #1;
    rx_a = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    e.data = 8'h55; e.perr = 1'b0; e.ferr = 1'b0;
    exp_a.push_back(e);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_got(1'b0, ok);
    e = exp_a.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL after_break timeout want=%h", e.data);
    end else begin
      g = got_a.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL after_break got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
      end
    end
  endtask

  task automatic test_glitch();
    int   r0;
    logic saw, b45;
    r0 = rise_cnt_a;
    saw = 1'b0;
    b45 = 1'bx;
    @(posedge clk); #1;
    rx_a = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 16) rx_a = 1'b1;
      if (busy_a === 1'b1) saw = 1'b1;
      if (k == 45) b45 = busy_a;
    end
    total++;
    if (saw !== 1'b1) begin
      bad++; $display("FAIL glitch_busy_pulse got=%b want=1", saw);
    end
    total++;
    if (b45 !== 1'b0) begin
      bad++; $display("FAIL glitch_busy_mid got=%b want=0", b45);
    end
    repeat (700) @(posedge clk);
    total++;
    if (rise_cnt_a != r0) begin
      bad++; $display("FAIL glitch_no_output valid_rises=%0d want=0", rise_cnt_a - r0);
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, g;
    bit   ok;
    int   o0;
    @(posedge clk); #1;
    rdy_a = 1'b0;
    o0 = ovr_cnt_a;
    e.data = 8'h11; e.perr = 1'b0; e.ferr = 1'b0;
    exp_a.push_back(e);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (ovr_cnt_a - o0 != 1) begin
      bad++; $display("FAIL overrun_pulses got=%0d want=1", ovr_cnt_a - o0);
    end
    total++;
    if (dout_a !== 8'h11 || vld_a !== 1'b1) begin
      bad++; $display("FAIL overrun_hold got=%h/%b want=11/1", dout_a, vld_a);
    end
    @(posedge clk); #1;
    rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (vld_a !== 1'b0) begin
      bad++; $display("FAIL accept_clear got=%b want=0", vld_a);
    end
    wait_got(1'b0, ok);
    e = exp_a.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_word timeout want=%h", e.data);
    end else begin
      g = got_a.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL b2b_word got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, g;
    bit   ok;
    logic [7:0] d;
    d = 8'h7E;
    repeat (BIT_CLK) @(posedge clk);
    @(posedge clk); #1;
    rx_a = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx_a = d[i];
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    rx_a = d[4];
    repeat (BIT_CLK / 2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy_a !== 1'b1) begin
      bad++; $display("FAIL midframe_busy got=%b want=1", busy_a);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({vld_a, perr_a, ferr_a, ovr_a, busy_a, dout_a} !== 13'b0) begin
      bad++;
      $display("FAIL midframe_reset got=%b want=0", {vld_a, perr_a, ferr_a, ovr_a, busy_a, dout_a});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rx_a = 1'b1;
    repeat (100) @(posedge clk);
    e.data = 8'h7E; e.perr = 1'b0; e.ferr = 1'b0;
    exp_a.push_back(e);
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    wait_got(1'b0, ok);
    e = exp_a.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL resend_word timeout want=%h", e.data);
    end else begin
      g = got_a.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL resend_word got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
      end
    end
  endtask

  task automatic test_leftovers();
    repeat (20) @(negedge clk);
    total++;
    if (got_a.size() != 0 || got_b.size() != 0) begin
      bad++; $display("FAIL stray_words got=%0d/%0d want=0/0", got_a.size(), got_b.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    baud_div = 16'd3;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_leftovers();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
